// File: rtl/ir_pkg.sv
// Shared types and defaults for the IR packet transmitter.
// Shadow timing fields are IR_SIZE_W / IR_DIV_W wide; widen these to support larger SIZE_W / DIV_W.
package ir_pkg;

    localparam int IR_SIZE_W = 8;
    localparam int IR_DIV_W  = 16;

    // Default car timing: ~38 kHz carrier from a 50 MHz clock
    localparam logic [IR_DIV_W-1:0]  IR_DEF_DIV_MAX       = 16'd657;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_START_SIZE    = 8'd96;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_SELECT_SIZE   = 8'd48;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_GAP_SIZE      = 8'd24;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_ASSERT_SIZE   = 8'd48;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_DEASSERT_SIZE = 8'd24;
    localparam logic [IR_SIZE_W-1:0] IR_DEF_HOLD_SIZE     = 8'd200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_HOLD  = 2'd3
    } ir_state_t;

    typedef struct packed {
        logic [IR_DIV_W-1:0]  div_max;
        logic [IR_SIZE_W-1:0] start_size;
        logic [IR_SIZE_W-1:0] select_size;
        logic [IR_SIZE_W-1:0] gap_size;
        logic [IR_SIZE_W-1:0] assert_size;
        logic [IR_SIZE_W-1:0] deassert_size;
        logic [IR_SIZE_W-1:0] hold_size;
    } ir_timing_t;

    // Period count at which a segment of the given size ends; size 0 behaves as 1.
    function automatic logic [IR_SIZE_W-1:0] seg_last(input logic [IR_SIZE_W-1:0] size);
        return (size == '0) ? '0 : size - IR_SIZE_W'(1);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider: toggles the carrier every div_max+1 cycles while enabled.
// period_end flags the edge where the carrier rises again (end of one full period).
module ir_carrier_gen
    import ir_pkg::*;
#(
    parameter int DIV_W = IR_DIV_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div_max,
    output logic             carrier,
    output logic             wrap,
    output logic             period_end
);

    logic [DIV_W-1:0] div_cnt;
    logic             carrier_nxt;

    assign wrap       = en && (div_cnt == div_max);
    assign period_end = wrap && !carrier;

    always_comb begin
        carrier_nxt = 1'b0;
        if (restart)
            carrier_nxt = 1'b1;
        else if (en)
            carrier_nxt = carrier ^ wrap;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt <= '0;
            carrier <= 1'b0;
        end else begin
            if (restart || !en || wrap)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);
            carrier <= carrier_nxt;
        end
    end

endmodule

// File: rtl/ir_packet_tx.sv
// IR packet transmitter: start, select and CMD_LEN command-bit bursts, each followed by a gap,
// with SEND/BUSY/DONE handshake and optional auto-repeat after a programmable hold.
module ir_packet_tx
    import ir_pkg::*;
#(
    parameter int CMD_LEN = 4,
    parameter int SIZE_W  = IR_SIZE_W,
    parameter int DIV_W   = IR_DIV_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SEND,
    input  logic [CMD_LEN-1:0] COMMAND,
    input  logic [DIV_W-1:0]   DIV_MAX,
    input  logic [SIZE_W-1:0]  START_SIZE,
    input  logic [SIZE_W-1:0]  SELECT_SIZE,
    input  logic [SIZE_W-1:0]  GAP_SIZE,
    input  logic [SIZE_W-1:0]  ASSERT_SIZE,
    input  logic [SIZE_W-1:0]  DEASSERT_SIZE,
    input  logic               REPEAT_EN,
    input  logic [SIZE_W-1:0]  HOLD_SIZE,
    output logic               BUSY,
    output logic               DONE,
    output logic               IR_LED
);

    localparam int              SEG_W    = $clog2(CMD_LEN + 2);
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(CMD_LEN + 1);

    ir_state_t            state, state_nxt;
    logic [SEG_W-1:0]     seg, seg_nxt;
    logic [IR_SIZE_W-1:0] pcnt, pcnt_nxt, size_cur;
    ir_timing_t           tm;
    logic [CMD_LEN-1:0]   cmd_sh;
    logic                 load, restart, done_nxt, cur_bit, seg_done, led_nxt;
    logic                 carrier, wrap, period_end;

    assign BUSY = (state != ST_IDLE);

    ir_carrier_gen #(.DIV_W(IR_DIV_W)) u_carrier (
        .CLK        (CLK),
        .RESET      (RESET),
        .en         (BUSY),
        .restart    (restart),
        .div_max    (tm.div_max),
        .carrier    (carrier),
        .wrap       (wrap),
        .period_end (period_end)
    );

    always_comb begin
        cur_bit = 1'b0;
        for (int i = 0; i < CMD_LEN; i++)
            if (seg == SEG_W'(i + 2))
                cur_bit = cmd_sh[i];
    end

    always_comb begin
        size_cur = '0;
        case (state)
            ST_MARK: begin
                if (seg == '0)
                    size_cur = tm.start_size;
                else if (seg == SEG_W'(1))
                    size_cur = tm.select_size;
                else
                    size_cur = cur_bit ? tm.assert_size : tm.deassert_size;
            end
            ST_SPACE: size_cur = tm.gap_size;
            ST_HOLD:  size_cur = tm.hold_size;
            default:  size_cur = '0;
        endcase
    end

    // Segments only ever end on a carrier period boundary
    assign seg_done = period_end && (pcnt == seg_last(size_cur));

    always_comb begin
        state_nxt = state;
        seg_nxt   = seg;
        pcnt_nxt  = period_end ? pcnt + IR_SIZE_W'(1) : pcnt;
        load      = 1'b0;
        restart   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                pcnt_nxt = '0;
                if (SEND) begin
                    load      = 1'b1;
                    restart   = 1'b1;
                    seg_nxt   = '0;
                    state_nxt = ST_MARK;
                end
            end
            ST_MARK: begin
                if (seg_done) begin
                    pcnt_nxt  = '0;
                    state_nxt = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (seg_done) begin
                    pcnt_nxt = '0;
                    if (seg != SEG_LAST) begin
                        seg_nxt   = seg + SEG_W'(1);
                        state_nxt = ST_MARK;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = REPEAT_EN ? ST_HOLD : ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (!REPEAT_EN) begin
                    pcnt_nxt  = '0;
                    state_nxt = ST_IDLE;
                end else if (seg_done) begin
                    pcnt_nxt  = '0;
                    load      = 1'b1;
                    restart   = 1'b1;
                    seg_nxt   = '0;
                    state_nxt = ST_MARK;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Entering MARK always coincides with a carrier rise (restart or period end)
    assign led_nxt = (state_nxt == ST_MARK) && (restart || (carrier ^ wrap));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            seg    <= '0;
            pcnt   <= '0;
            tm     <= '0;
            cmd_sh <= '0;
            DONE   <= 1'b0;
            IR_LED <= 1'b0;
        end else begin
            state  <= state_nxt;
            seg    <= seg_nxt;
            pcnt   <= pcnt_nxt;
            DONE   <= done_nxt;
            IR_LED <= led_nxt;
            if (load) begin
                tm <= '{div_max:       IR_DIV_W'(DIV_MAX),
                        start_size:    IR_SIZE_W'(START_SIZE),
                        select_size:   IR_SIZE_W'(SELECT_SIZE),
                        gap_size:      IR_SIZE_W'(GAP_SIZE),
                        assert_size:   IR_SIZE_W'(ASSERT_SIZE),
                        deassert_size: IR_SIZE_W'(DEASSERT_SIZE),
                        hold_size:     IR_SIZE_W'(HOLD_SIZE)};
                cmd_sh <= COMMAND;
            end
        end
    end

endmodule

// File: tb/tb_ir_packet_tx.sv
// Directed bench for ir_packet_tx: single packet, shadowing, busy SEND, repeat, reset, zero sizes.
module tb_ir_packet_tx;

    logic        CLK, RESET, SEND, REPEAT_EN;
    logic [3:0]  COMMAND;
    logic [15:0] DIV_MAX;
    logic [7:0]  START_SIZE, SELECT_SIZE, GAP_SIZE, ASSERT_SIZE, DEASSERT_SIZE, HOLD_SIZE;
    logic        BUSY, DONE, IR_LED;

    int checks = 0;
    int errors = 0;

    logic exp_led1 [0:71];
    logic cap_led  [0:199];
    logic cap_busy [0:199];
    logic cap_done [0:199];

    ir_packet_tx #(.CMD_LEN(4), .SIZE_W(8), .DIV_W(16)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SEND          (SEND),
        .COMMAND       (COMMAND),
        .DIV_MAX       (DIV_MAX),
        .START_SIZE    (START_SIZE),
        .SELECT_SIZE   (SELECT_SIZE),
        .GAP_SIZE      (GAP_SIZE),
        .ASSERT_SIZE   (ASSERT_SIZE),
        .DEASSERT_SIZE (DEASSERT_SIZE),
        .REPEAT_EN     (REPEAT_EN),
        .HOLD_SIZE     (HOLD_SIZE),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .IR_LED        (IR_LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference LED waveform for the base config: bursts 3,2,2,1,1,2 periods, 4-cycle gaps
    task automatic build_expected();
        int bursts [6] = '{3, 2, 2, 1, 1, 2};
        int idx = 0;
        for (int c = 0; c < 72; c++) exp_led1[c] = 1'b0;
        for (int b = 0; b < 6; b++) begin
            for (int p = 0; p < bursts[b]; p++) begin
                exp_led1[idx]   = 1'b1;
                exp_led1[idx+1] = 1'b1;
                idx += 4;
            end
            idx += 4;
        end
    endtask

    task automatic set_cfg1();
        COMMAND = 4'b1001; DIV_MAX = 16'd1;
        START_SIZE = 8'd3; SELECT_SIZE = 8'd2; GAP_SIZE = 8'd1;
        ASSERT_SIZE = 8'd2; DEASSERT_SIZE = 8'd1;
        REPEAT_EN = 1'b0; HOLD_SIZE = 8'd0;
    endtask

    // Called at a negedge; SEND is sampled at the following posedge (cycle 0 starts after it)
    task automatic send_pulse();
        SEND = 1'b1;
        @(negedge CLK);
        SEND = 1'b0;
    endtask

    // Record n cycles; mode 1 = change inputs, 2 = pulse SEND, 3 = drop REPEAT_EN, 4 = pulse RESET at cycle 'at'
    task automatic capture(input int n, input int mode, input int at);
        for (int c = 0; c < n; c++) begin
            cap_led[c]  = IR_LED;
            cap_busy[c] = BUSY;
            cap_done[c] = DONE;
            if (c == at) begin
                case (mode)
                    1: begin
                        COMMAND = 4'b0110; DIV_MAX = 16'd0;
                        START_SIZE = 8'd1; SELECT_SIZE = 8'd1; GAP_SIZE = 8'd1;
                        ASSERT_SIZE = 8'd1; DEASSERT_SIZE = 8'd1;
                    end
                    2: SEND = 1'b1;
                    3: REPEAT_EN = 1'b0;
                    4: RESET = 1'b1;
                    default: ;
                endcase
            end
            if (c == at + 1) begin
                SEND  = 1'b0;
                RESET = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; SEND = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL reset BUSY got %b exp 0", BUSY); end
        checks++; if (DONE !== 1'b0)   begin errors++; $display("FAIL reset DONE got %b exp 0", DONE); end
        checks++; if (IR_LED !== 1'b0) begin errors++; $display("FAIL reset IR_LED got %b exp 0", IR_LED); end
        RESET = 1'b0; SEND = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL idle BUSY got %b exp 0", BUSY); end
    endtask

    task automatic test_single_packet();
        set_cfg1();
        send_pulse();
        capture(72, 0, -1);
        for (int c = 0; c < 72; c++) begin
            checks++; if (cap_led[c] !== exp_led1[c])
                begin errors++; $display("FAIL single led c=%0d got %b exp %b", c, cap_led[c], exp_led1[c]); end
            checks++; if (cap_busy[c] !== (c < 68))
                begin errors++; $display("FAIL single busy c=%0d got %b exp %b", c, cap_busy[c], c < 68); end
            checks++; if (cap_done[c] !== (c == 68))
                begin errors++; $display("FAIL single done c=%0d got %b exp %b", c, cap_done[c], c == 68); end
        end
    endtask

    task automatic test_mid_change();
        int nb = 0;
        set_cfg1();
        send_pulse();
        capture(72, 1, 10);
        for (int c = 0; c < 72; c++) begin
            checks++; if (cap_led[c] !== exp_led1[c])
                begin errors++; $display("FAIL shadow led c=%0d got %b exp %b", c, cap_led[c], exp_led1[c]); end
            checks++; if (cap_done[c] !== (c == 68))
                begin errors++; $display("FAIL shadow done c=%0d got %b exp %b", c, cap_done[c], c == 68); end
        end
        // Resend picks up the new config: 12 one-period segments at DIV_MAX 0
        send_pulse();
        capture(30, 0, -1);
        for (int c = 0; c < 30; c++) if (cap_busy[c] === 1'b1) nb++;
        checks++; if (nb != 24) begin errors++; $display("FAIL relatch busy_len got %0d exp 24", nb); end
        checks++; if (cap_done[24] !== 1'b1) begin errors++; $display("FAIL relatch done@24 got %b exp 1", cap_done[24]); end
        checks++; if (cap_led[1] !== 1'b0) begin errors++; $display("FAIL relatch led c=1 got %b exp 0", cap_led[1]); end
    endtask

    task automatic test_send_busy();
        set_cfg1();
        send_pulse();
        capture(72, 2, 20);
        for (int c = 0; c < 72; c++) begin
            checks++; if (cap_led[c] !== exp_led1[c])
                begin errors++; $display("FAIL busy_send led c=%0d got %b exp %b", c, cap_led[c], exp_led1[c]); end
            checks++; if (cap_done[c] !== (c == 68))
                begin errors++; $display("FAIL busy_send done c=%0d got %b exp %b", c, cap_done[c], c == 68); end
        end
    endtask

    task automatic test_repeat();
        logic el;
        set_cfg1();
        REPEAT_EN = 1'b1; HOLD_SIZE = 8'd5;
        send_pulse();
        capture(166, 3, 160);
        for (int c = 0; c < 166; c++) begin
            el = 1'b0;
            if (c < 68) el = exp_led1[c];
            else if (c >= 88 && c < 156) el = exp_led1[c-88];
            checks++; if (cap_led[c] !== el)
                begin errors++; $display("FAIL repeat led c=%0d got %b exp %b", c, cap_led[c], el); end
            checks++; if (cap_busy[c] !== (c < 161))
                begin errors++; $display("FAIL repeat busy c=%0d got %b exp %b", c, cap_busy[c], c < 161); end
            checks++; if (cap_done[c] !== (c == 68 || c == 156))
                begin errors++; $display("FAIL repeat done c=%0d got %b exp %b", c, cap_done[c], c == 68 || c == 156); end
        end
        HOLD_SIZE = 8'd0;
    endtask

    task automatic test_reset_mid();
        set_cfg1();
        send_pulse();
        capture(35, 4, 30);
        for (int c = 0; c < 35; c++) begin
            checks++; if (cap_led[c] !== ((c < 31) ? exp_led1[c] : 1'b0))
                begin errors++; $display("FAIL rstmid led c=%0d got %b", c, cap_led[c]); end
            checks++; if (cap_busy[c] !== (c < 31))
                begin errors++; $display("FAIL rstmid busy c=%0d got %b exp %b", c, cap_busy[c], c < 31); end
            checks++; if (cap_done[c] !== 1'b0)
                begin errors++; $display("FAIL rstmid done c=%0d got %b exp 0", c, cap_done[c]); end
        end
        send_pulse();
        capture(72, 0, -1);
        for (int c = 0; c < 72; c++) begin
            checks++; if (cap_led[c] !== exp_led1[c])
                begin errors++; $display("FAIL rstmid resend led c=%0d got %b exp %b", c, cap_led[c], exp_led1[c]); end
            checks++; if (cap_done[c] !== (c == 68))
                begin errors++; $display("FAIL rstmid resend done c=%0d got %b exp %b", c, cap_done[c], c == 68); end
        end
    endtask

    task automatic test_zero_sizes();
        set_cfg1();
        DIV_MAX = 16'd0; START_SIZE = 8'd0; SELECT_SIZE = 8'd0; GAP_SIZE = 8'd0;
        ASSERT_SIZE = 8'd0; DEASSERT_SIZE = 8'd0;
        send_pulse();
        capture(28, 0, -1);
        for (int c = 0; c < 28; c++) begin
            checks++; if (cap_led[c] !== (c < 24 && (c % 4) == 0))
                begin errors++; $display("FAIL zero led c=%0d got %b exp %b", c, cap_led[c], c < 24 && (c % 4) == 0); end
            checks++; if (cap_busy[c] !== (c < 24))
                begin errors++; $display("FAIL zero busy c=%0d got %b exp %b", c, cap_busy[c], c < 24); end
            checks++; if (cap_done[c] !== (c == 24))
                begin errors++; $display("FAIL zero done c=%0d got %b exp %b", c, cap_done[c], c == 24); end
        end
    endtask

    initial begin
        RESET = 1'b1; SEND = 1'b0;
        set_cfg1();
        build_expected();
        @(negedge CLK);
        test_reset();
        test_single_packet();
        test_mid_change();
        test_send_busy();
        test_repeat();
        test_reset_mid();
        test_zero_sizes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_packet_tx.md
# ir_packet_tx

Parametrised IR packet transmitter that serialises a start burst, a car-select burst and `CMD_LEN` command-bit bursts. Each burst is followed by a gap. Every burst modulates the IR LED with a carrier derived from `CLK`. Compared with the fixed four-command transmitter, it adds the following:
- Command and packet timing are latched at packet start.
- `SEND`/`BUSY`/`DONE` handshake.
- Optional auto-repeat with a programmable inter-packet hold.

It sits between the command/bus-interface logic and the IR LED pin.

## Interface
- `CMD_LEN`, 4: number of command bits per packet (≥1); bit 0 is sent first.
- `SIZE_W`, 8: width of every burst/gap size field (carrier periods).
- `DIV_W`, 16: width of the carrier divider.
- `CLK`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high.
- `SEND`  in  1  packet request; sampled only in IDLE.
- `COMMAND`  in  `CMD_LEN`  command bits; 1 = asserted.
- `DIV_MAX`  in  `DIV_W`  carrier half-period minus one, in `CLK` cycles.
- `START_SIZE`, `SELECT_SIZE`, `GAP_SIZE`, `ASSERT_SIZE`, `DEASSERT_SIZE`  in  `SIZE_W` each  burst lengths in carrier periods.
- `REPEAT_EN`  in  1  auto-resend enable.
- `HOLD_SIZE`  in  `SIZE_W`  inter-packet hold, in carrier periods.
- `BUSY`  out  1  packet or hold in progress.
- `DONE`  out  1  one-cycle pulse at end of each packet's final gap.
- `IR_LED`  out  1  modulated LED drive, registered.

## Operation
- **States:** IDLE, MARK, SPACE, HOLD. Segment index `seg` runs 0..`CMD_LEN`+1:
  - 0 = start burst.
  - 1 = select burst.
  - 2+i = `COMMAND` bit i.
- **IDLE + `SEND`=1:**
  - Latch `COMMAND`, all sizes and `DIV_MAX` into shadow registers.
  - Set `seg`=0 and enter MARK.
  - Start the carrier high with the divider at 0.
- **MARK length** is set by `seg`:
  - `seg` 0: `START_SIZE`.
  - `seg` 1: `SELECT_SIZE`.
  - Bit segments: `ASSERT_SIZE` if the latched bit is 1, else `DEASSERT_SIZE`.
- **MARK → SPACE** after that length. SPACE lasts `GAP_SIZE`.
- **SPACE end:**
  - If `seg` < `CMD_LEN`+1: increment `seg` and return to MARK.
  - Otherwise pulse `DONE`. Then go to HOLD if `REPEAT_EN`=1, else IDLE.
- **HOLD** lasts `HOLD_SIZE` periods, then re-latches all inputs and enters MARK with `seg`=0, as on a new `SEND`.
- **`REPEAT_EN` low during HOLD:** return to IDLE on the next edge.
- **`SEND` outside IDLE** is ignored. There is no restart and no queueing.
- **Size value 0** is treated as 1, so every segment is at least one carrier period.
- **`IR_LED`** equals the carrier in MARK and is 0 in SPACE, HOLD and IDLE.
- **Shadow registers** are used throughout, so input changes mid-packet have no effect.
- **`BUSY`** is 1 in MARK, SPACE and HOLD, and 0 in IDLE.

## Timing
- **Carrier:**
  - The divider counts 0..`DIV_MAX`. On the wrap it toggles the carrier.
  - Period = 2·(`DIV_MAX`+1) cycles; 50 % duty.
  - The carrier runs only while BUSY and is phase-reset at each packet start.
- **Carrier period end** is the wrap edge where the carrier goes 0→1. It increments the segment period counter.
- **Segment transitions** occur on the period-end edge at which count = size. All segments are therefore aligned to the carrier rising edge.
- **Packet length:**
  - Duration = 2·(`DIV_MAX`+1)·(`START`+`SELECT`+Σbit sizes+(`CMD_LEN`+2)·`GAP`) cycles.
  - `SEND` sampled at edge k gives `BUSY`=1 and `IR_LED`=1 after edge k (zero-cycle latency to first mark).
- **`DONE`:**
  - Asserted for the cycle after the final period-end edge.
  - `BUSY` drops on that same edge if not repeating.
  - A new `SEND` is accepted on the edge after `BUSY` falls.
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Reset mid-packet:** `IR_LED` and `BUSY` are 0 after the reset edge, and `DONE` is not pulsed.

## Structure
- **Shared package `ir_pkg`** holds:
  - The `ir_state_t` enum.
  - A `ir_timing_t` struct: sizes, `DIV_MAX`, `HOLD_SIZE`.
  - Default car timing constants.
- **Sub-module `ir_carrier_gen`:** divider plus carrier flop, with outputs `carrier` and `period_end`, and an enable/restart input.
- **Top:** FSM, segment/period counters and shadow registers.

## Test plan
1. **Single packet:**
   - Setup: `CMD_LEN`=4, `DIV_MAX`=1, START=3, GAP=1, SELECT=2, ASSERT=2, DEASSERT=1, `COMMAND`=4'b1001, one `SEND` pulse.
   - Expect: `BUSY` high for exactly 68 cycles; `DONE` one cycle at cycle 68.
   - Expect `IR_LED` bursts of 3, 2, 2, 1, 1, 2 carrier periods (each 2 high/2 low), with 4-cycle low gaps between bursts.
2. **Mid-packet changes:** from (1), change `COMMAND` and sizes mid-packet, then resend → the first packet is identical to (1).
3. **`SEND` while busy:** from (1), pulse `SEND` at cycle 20 → no restart; `DONE` is still at cycle 68.
4. **Repeat:**
   - From (1) with `REPEAT_EN`=1 and `HOLD_SIZE`=5: after `DONE`, expect 20 cycles of low `IR_LED` with `BUSY`=1, then an identical packet.
   - Drop `REPEAT_EN` during HOLD → `BUSY`=0 on the next edge.
5. **Reset mid-packet:** assert `RESET` at cycle 30 → `IR_LED`, `BUSY`, `DONE` are 0 after the edge. A `SEND` at cycle 35 reproduces (1).
6. **Zero sizes:** all sizes 0, `DIV_MAX`=0 → each segment is 1 period (2 cycles); packet = 2·(2+4+6) = 24 cycles.
